mac_array_parallel: RTL and testbench
=====================================

Name: mac_array_parallel

Overview:
Parameterised, pipelined multi-lane MAC. Each valid beat multiplies NUM_LANES activation/weight pairs and reduces them in an adder tree. The tree sum is folded into an accumulator over ACC_LEN beats, then one result is emitted with a valid pulse. It generalises the single-lane 8-bit parallel MAC and adds lane count, accumulation depth, signed/unsigned mode, stall and result handshake. It sits in the PE array as the bit-parallel baseline compute unit.

Parameters:
DATA_WIDTH, 8, operand width per lane
NUM_LANES, 4, parallel multiplier lanes (power of 2, >=1)
ACC_LEN, 16, beats accumulated per result (>=1)
ACC_WIDTH, 2*DATA_WIDTH+16, accumulator / accum_prev / result width
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
en  in  1  pipeline advance; 0 = full stall, all state held
in_valid  in  1  act/w beat valid this cycle
load_accum  in  1  with in_valid: first beat seeds accumulator from accum_prev
act  in  NUM_LANES*DATA_WIDTH  packed activations, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
w  in  NUM_LANES*DATA_WIDTH  packed weights, same packing
accum_prev  in  ACC_WIDTH  seed value, sampled with a load_accum beat
result  out  ACC_WIDTH  accumulated result
result_valid  out  1  one-cycle pulse, result valid
beat_cnt  out  clog2(ACC_LEN)+1  beats accumulated so far in current group

Behaviour:
- Only clk and reset are used. All registers reset to 0 on reset, including result, result_valid, beat_cnt and every pipeline valid bit. Reset overrides en.
- Pipeline, all stages gated by en:
  - S1 registers act, w, in_valid, load_accum and accum_prev.
  - S2 registers NUM_LANES products of 2*DATA_WIDTH each. Operands are sign-extended if SIGNED, else zero-extended.
  - S3 registers the tree sum, width 2*DATA_WIDTH+clog2(NUM_LANES), sign/zero-extended per SIGNED.
  - S4 accumulates.
- Latency: a beat sampled at edge k reaches the accumulator at edge k+3. For the last beat of a group, result and result_valid update at edge k+3 and are visible the cycle after.
- S4 on a valid beat:
  - load_accum=1: acc = accum_prev + sum, beat_cnt = 1. This restarts the group and discards any partial group.
  - load_accum=0: acc = acc + sum, beat_cnt += 1.
  - Sum is extended to ACC_WIDTH before the add. Without the optional feature, overflow wraps modulo 2^ACC_WIDTH.
- Group completion: when the incremented beat_cnt equals ACC_LEN:
  - result <= new acc value and result_valid <= 1 for one cycle.
  - acc <= 0 and beat_cnt <= 0. The next beat starts a fresh group (seed 0 unless load_accum).
- ACC_LEN=1: every valid beat produces a result.
- No valid beat at S4: acc and beat_cnt hold, result_valid <= 0.
- result holds its last value until the next completion.
- en=0: no register changes. result_valid also holds, so a pulse stretches across the stall. Consumers qualify it with en.
- Bubbles (in_valid=0) do not count toward ACC_LEN.
- in_valid=0 with load_accum=1: load_accum is ignored.
- Reset mid-group: partial accumulation and in-flight beats are dropped; no result is emitted.

Optional Feature:
Macro MAC_ARRAY_ACC_SAT_EN.
- Defined: the S4 add saturates to the signed ACC_WIDTH range (SIGNED=1) or to [0, 2^ACC_WIDTH-1] (SIGNED=0). An extra output sat_flag (1 bit, reset 0) pulses with result_valid if any add in that group saturated.
- Undefined: wrap-around arithmetic and no sat_flag port.

Test Plan:
1. Defaults, SIGNED=1, 16 beats all lanes act=3, w=-2, first beat load_accum=1 with accum_prev=100 -> one result_valid pulse 3 cycles after the last beat sample, result = 100 + 16*4*(-6) = -284.
2. SIGNED=0, DATA_WIDTH=8, lanes act=255, w=255, ACC_LEN=1 -> result=260100 each beat, result_valid every cycle of a back-to-back stream.
3. Bubbles and stall: 16 beats of act=1, w=1 with 5 in_valid=0 gaps and en=0 for 3 cycles mid-group -> result=64, exactly one pulse, beat_cnt unchanged while en=0.
4. Restart: 7 beats, then load_accum=1 with accum_prev=0, then 16 more beats of act=1, w=1 -> single result=64; the first 7 beats are discarded.
5. Reset asserted at beat 10 of a group -> all outputs 0 next cycle, no pulse. A new 16-beat group of act=2, w=2 -> result=256.
6. ACC_WIDTH=20, SIGNED=1, accumulate past 2^19-1 -> without the macro, result wraps negative; with MAC_ARRAY_ACC_SAT_EN, result=524287 and sat_flag=1.

Source files
------------

// File: rtl/mac_array_parallel.sv
// Pipelined multi-lane MAC: lane products -> adder tree -> group accumulator with result pulse.
// Optional MAC_ARRAY_ACC_SAT_EN: saturating accumulator add plus a sat_flag output.
module mac_array_parallel #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int ACC_LEN    = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+16,
  parameter int SIGNED     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              in_valid,
  input  logic                              load_accum,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   act,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   w,
  input  logic [ACC_WIDTH-1:0]              accum_prev,
  output logic [ACC_WIDTH-1:0]              result,
  output logic                              result_valid,
`ifdef MAC_ARRAY_ACC_SAT_EN
  output logic                              sat_flag,
`endif
  output logic [$clog2(ACC_LEN):0]          beat_cnt
);

  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);
  localparam int CNT_W  = $clog2(ACC_LEN) + 1;
  localparam int LANE_W = NUM_LANES*DATA_WIDTH;
  localparam logic SGN  = (SIGNED != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN);

  function automatic logic [PROD_W-1:0] op_ext(input logic [DATA_WIDTH-1:0] x);
    return {{DATA_WIDTH{x[DATA_WIDTH-1] & SGN}}, x};
  endfunction

  function automatic logic [SUM_W-1:0] prod_ext(input logic [PROD_W-1:0] p);
    logic [SUM_W-1:0] r;
    r = '0;
    r[PROD_W-1:0] = p;
    for (int i = PROD_W; i < SUM_W; i++) r[i] = p[PROD_W-1] & SGN;
    return r;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sum_ext(input logic [SUM_W-1:0] s);
    logic [ACC_WIDTH-1:0] r;
    r = '0;
    r[SUM_W-1:0] = s;
    for (int i = SUM_W; i < ACC_WIDTH; i++) r[i] = s[SUM_W-1] & SGN;
    return r;
  endfunction

`ifdef MAC_ARRAY_ACC_SAT_EN
  // Returns {saturated, clamped sum}; clamps to the signed or unsigned ACC_WIDTH range.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    logic               ovf;
    s = {1'b0, a} + {1'b0, b};
    if (SGN) begin
      ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
      if (ovf)
        s[ACC_WIDTH-1:0] = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      ovf = s[ACC_WIDTH];
      if (ovf) s[ACC_WIDTH-1:0] = '1;
    end
    return {ovf, s[ACC_WIDTH-1:0]};
  endfunction
`else
  function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
    return a + b;
  endfunction
`endif

  logic [LANE_W-1:0]              r_act_p0, r_w_p0;
  logic [ACC_WIDTH-1:0]           r_prev_p0, r_prev_p1, r_prev_p2;
  logic                           r_vld_p0, r_vld_p1, r_vld_p2;
  logic                           r_load_p0, r_load_p1, r_load_p2;
  logic [NUM_LANES-1:0][PROD_W-1:0] r_prod_p1;
  logic [SUM_W-1:0]               r_sum_p2;
  logic [ACC_WIDTH-1:0]           r_acc, r_result;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_result_valid;

  logic [SUM_W-1:0]               w_tree_sum;
  logic [ACC_WIDTH-1:0]           w_base, w_acc_nxt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic                           w_done;

  // S1: input capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_p0  <= '0;
      r_w_p0    <= '0;
      r_prev_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_load_p0 <= 1'b0;
    end else if (en) begin
      r_act_p0  <= act;
      r_w_p0    <= w;
      r_prev_p0 <= accum_prev;
      r_vld_p0  <= in_valid;
      r_load_p0 <= in_valid & load_accum;
    end
  end

  // S2: per-lane products
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod_p1 <= '0;
      r_prev_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_load_p1 <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NUM_LANES; i++)
        r_prod_p1[i] <= op_ext(r_act_p0[i*DATA_WIDTH +: DATA_WIDTH]) *
                        op_ext(r_w_p0[i*DATA_WIDTH +: DATA_WIDTH]);
      r_prev_p1 <= r_prev_p0;
      r_vld_p1  <= r_vld_p0;
      r_load_p1 <= r_load_p0;
    end
  end

  always_comb begin
    w_tree_sum = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_tree_sum = w_tree_sum + prod_ext(r_prod_p1[i]);
  end

  // S3: reduced lane sum
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_p2  <= '0;
      r_prev_p2 <= '0;
      r_vld_p2  <= 1'b0;
      r_load_p2 <= 1'b0;
    end else if (en) begin
      r_sum_p2  <= w_tree_sum;
      r_prev_p2 <= r_prev_p1;
      r_vld_p2  <= r_vld_p1;
      r_load_p2 <= r_load_p1;
    end
  end

  // A load beat restarts the group from the seed, discarding any partial sum.
  assign w_base    = r_load_p2 ? r_prev_p2 : r_acc;
  assign w_cnt_nxt = r_load_p2 ? CNT_ONE : (r_cnt + CNT_ONE);
  assign w_done    = (w_cnt_nxt == CNT_LAST);

`ifdef MAC_ARRAY_ACC_SAT_EN
  logic w_sat_now, w_grp_nxt, r_sat_grp, r_sat_flag;
  assign {w_sat_now, w_acc_nxt} = sat_add(w_base, sum_ext(r_sum_p2));
  assign w_grp_nxt = r_load_p2 ? w_sat_now : (r_sat_grp | w_sat_now);
  assign sat_flag  = r_sat_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_grp  <= 1'b0;
      r_sat_flag <= 1'b0;
    end else if (en) begin
      r_sat_flag <= r_vld_p2 & w_done & w_grp_nxt;
      if (r_vld_p2) r_sat_grp <= w_done ? 1'b0 : w_grp_nxt;
    end
  end
`else
  assign w_acc_nxt = wrap_add(w_base, sum_ext(r_sum_p2));
`endif

  // S4: accumulate and emit on group completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (en) begin
      r_result_valid <= 1'b0;
      if (r_vld_p2) begin
        if (w_done) begin
          r_result       <= w_acc_nxt;
          r_result_valid <= 1'b1;
          r_acc          <= '0;
          r_cnt          <= '0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign beat_cnt     = r_cnt;

endmodule

// File: tb/tb_mac_array_parallel.sv
// Scoreboard bench for mac_array_parallel: three configurations (default signed, unsigned ACC_LEN=1, 20-bit acc).
module tb_mac_array_parallel;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        load_accum = 1'b0;
  logic [31:0] act = '0;
  logic [31:0] wv = '0;
  logic [31:0] prev = '0;
  int          sel = 0;
  logic        iv_a, iv_b, iv_c;

  logic [31:0] res_a, res_b;
  logic [19:0] res_c;
  logic        rv_a, rv_b, rv_c;
  logic [4:0]  bc_a, bc_c;
  logic [0:0]  bc_b;
`ifdef MAC_ARRAY_ACC_SAT_EN
  logic        sat_a, sat_b, sat_c;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int p_a = 0;
  int AWD[3]  = '{32, 32, 20};
  int LENS[3] = '{16, 1, 16};
  bit SGN[3]  = '{1'b1, 1'b0, 1'b1};
  longint m_acc[3] = '{0, 0, 0};
  int     m_cnt[3] = '{0, 0, 0};
  bit     m_sat[3] = '{0, 0, 0};
  logic [31:0] q_a[$], q_b[$], q_c[$];
  bit          qs_c[$];

  assign iv_a = in_valid && (sel == 0);
  assign iv_b = in_valid && (sel == 1);
  assign iv_c = in_valid && (sel == 2);

  always #5 clk = ~clk;

  mac_array_parallel dut_a (
    .clk(clk), .reset(reset), .en(en), .in_valid(iv_a), .load_accum(load_accum),
    .act(act), .w(wv), .accum_prev(prev), .result(res_a), .result_valid(rv_a),
`ifdef MAC_ARRAY_ACC_SAT_EN
    .sat_flag(sat_a),
`endif
    .beat_cnt(bc_a));

  mac_array_parallel #(.SIGNED(0), .ACC_LEN(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .in_valid(iv_b), .load_accum(load_accum),
    .act(act), .w(wv), .accum_prev(prev), .result(res_b), .result_valid(rv_b),
`ifdef MAC_ARRAY_ACC_SAT_EN
    .sat_flag(sat_b),
`endif
    .beat_cnt(bc_b));

  mac_array_parallel #(.ACC_WIDTH(20), .SIGNED(1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .in_valid(iv_c), .load_accum(load_accum),
    .act(act), .w(wv), .accum_prev(prev[19:0]), .result(res_c), .result_valid(rv_c),
`ifdef MAC_ARRAY_ACC_SAT_EN
    .sat_flag(sat_c),
`endif
    .beat_cnt(bc_c));

  // A pulse is consumed once per enabled cycle in which it is visible.
  always @(negedge clk) begin
    if (!reset && en && rv_a) begin
      logic [31:0] e;
      n_cmp++; p_a++;
      if (q_a.size() == 0) begin
        n_err++; $display("FAIL mon_a unexpected pulse: got %0d", $signed(res_a));
      end else begin
        e = q_a.pop_front();
        if (res_a !== e) begin
          n_err++; $display("FAIL mon_a result: got %0d want %0d", $signed(res_a), $signed(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && en && rv_b) begin
      logic [31:0] e;
      n_cmp++;
      if (q_b.size() == 0) begin
        n_err++; $display("FAIL mon_b unexpected pulse: got %0d", res_b);
      end else begin
        e = q_b.pop_front();
        if (res_b !== e) begin
          n_err++; $display("FAIL mon_b result: got %0d want %0d", res_b, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && en && rv_c) begin
      logic [31:0] e;
      bit          es;
      n_cmp++;
      if (q_c.size() == 0) begin
        n_err++; $display("FAIL mon_c unexpected pulse: got %h", res_c);
      end else begin
        e  = q_c.pop_front();
        es = qs_c.pop_front();
        if (res_c !== e[19:0]) begin
          n_err++; $display("FAIL mon_c result: got %h want %h", res_c, e[19:0]);
        end
`ifdef MAC_ARRAY_ACC_SAT_EN
        n_cmp++;
        if (sat_c !== es) begin
          n_err++; $display("FAIL mon_c sat_flag: got %b want %b", sat_c, es);
        end
`endif
      end
    end
  end

  function automatic longint fold(input longint v, input int d, output bit s);
    longint lim, r;
    lim = 64'sd1 <<< AWD[d];
    r = v;
    s = 1'b0;
`ifdef MAC_ARRAY_ACC_SAT_EN
    if (SGN[d]) begin
      if (r > lim/2 - 1) begin r = lim/2 - 1; s = 1'b1; end
      else if (r < -(lim/2)) begin r = -(lim/2); s = 1'b1; end
    end else if (r > lim - 1) begin
      r = lim - 1; s = 1'b1;
    end
`else
    r = r & (lim - 1);
    if (SGN[d] && r >= lim/2) r = r - lim;
`endif
    return r;
  endfunction

  task automatic model_beat(input int d, input logic [31:0] a, input logic [31:0] b,
                            input logic ld, input logic [31:0] p);
    longint s, x, y, base, lim, nv;
    bit st;
    lim = 64'sd1 <<< AWD[d];
    s = 0;
    for (int l = 0; l < 4; l++) begin
      if (SGN[d]) begin x = $signed(a[l*8 +: 8]); y = $signed(b[l*8 +: 8]); end
      else begin x = {56'b0, a[l*8 +: 8]}; y = {56'b0, b[l*8 +: 8]}; end
      s += x * y;
    end
    if (ld) begin
      base = {32'b0, p};
      base = base & (lim - 1);
      if (SGN[d] && base >= lim/2) base -= lim;
    end else begin
      base = m_acc[d];
    end
    nv = fold(base + s, d, st);
    m_sat[d] = ld ? st : (m_sat[d] | st);
    m_cnt[d] = ld ? 1 : m_cnt[d] + 1;
    if (m_cnt[d] == LENS[d]) begin
      case (d)
        0: q_a.push_back(nv[31:0]);
        1: q_b.push_back(nv[31:0]);
        default: begin q_c.push_back(nv[31:0]); qs_c.push_back(m_sat[d]); end
      endcase
      m_acc[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
    end else begin
      m_acc[d] = nv;
    end
  endtask

  task automatic beat(input int d, input logic [31:0] a, input logic [31:0] b,
                      input logic ld, input logic [31:0] p);
    sel = d; en = 1'b1; in_valid = 1'b1; load_accum = ld; act = a; wv = b; prev = p;
    model_beat(d, a, b, ld, p);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b1; in_valid = 1'b0; load_accum = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({res_a, rv_a, bc_a} !== '0) begin
      n_err++; $display("FAIL reset_a: got res=%h vld=%b cnt=%0d want 0", res_a, rv_a, bc_a);
    end
    n_cmp++;
    if ({res_b, rv_b, bc_b} !== '0) begin
      n_err++; $display("FAIL reset_b: got res=%h vld=%b cnt=%0d want 0", res_b, rv_b, bc_b);
    end
    n_cmp++;
    if ({res_c, rv_c, bc_c} !== '0) begin
      n_err++; $display("FAIL reset_c: got res=%h vld=%b cnt=%0d want 0", res_c, rv_c, bc_c);
    end
`ifdef MAC_ARRAY_ACC_SAT_EN
    n_cmp++;
    if ({sat_a, sat_b, sat_c} !== 3'b000) begin
      n_err++; $display("FAIL reset_sat: got %b%b%b want 000", sat_a, sat_b, sat_c);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_signed_basic;
    logic [31:0] want;
    int p0;
    want = 32'hFFFF_FEE4;  // -284
    p0 = p_a;
    beat(0, {4{8'd3}}, {4{8'hFE}}, 1'b1, 32'd100);
    repeat (15) beat(0, {4{8'd3}}, {4{8'hFE}}, 1'b0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      n_cmp++;
      if (rv_a !== 1'(i == 3)) begin
        n_err++; $display("FAIL latency cycle %0d: got vld=%b want %b", i, rv_a, (i == 3));
      end
    end
    n_cmp++;
    if (res_a !== want) begin
      n_err++; $display("FAIL signed_result: got %0d want -284", $signed(res_a));
    end
    idle(4);
    n_cmp++;
    if (p_a - p0 != 1 || q_a.size() != 0 || bc_a !== 5'd0) begin
      n_err++; $display("FAIL signed_pulses: got %0d pulses cnt=%0d pending=%0d want 1/0/0",
                        p_a - p0, bc_a, q_a.size());
    end
  endtask

  task automatic test_unsigned_stream;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) beat(1, {4{8'hFF}}, {4{8'hFF}}, 1'b0, 32'd0);
      else idle(1);
      n_cmp++;
      if (rv_b !== 1'(i >= 3 && i <= 8)) begin
        n_err++; $display("FAIL stream_vld cycle %0d: got %b want %b", i, rv_b, (i >= 3 && i <= 8));
      end
      if (i == 5) begin
        n_cmp++;
        if (res_b !== 32'd260100) begin
          n_err++; $display("FAIL stream_result: got %0d want 260100", res_b);
        end
      end
    end
    beat(1, 32'h0403_0201, 32'h0A14_1EC8, 1'b0, 32'd0);
    idle(5);
    n_cmp++;
    if (q_b.size() != 0) begin
      n_err++; $display("FAIL stream_drain: got %0d pending want 0", q_b.size());
    end
  endtask

  task automatic test_bubble_stall;
    int p0;
    p0 = p_a;
    repeat (6) beat(0, {4{8'd1}}, {4{8'd1}}, 1'b0, 32'd0);
    idle(2);
    en = 1'b0; in_valid = 1'b1; load_accum = 1'b1; sel = 0;
    act = 32'hFFFF_FFFF; wv = 32'h7F7F_7F7F; prev = 32'd999;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bc_a !== 5'd5 || rv_a !== 1'b0) begin
        n_err++; $display("FAIL stall_hold %0d: got cnt=%0d vld=%b want 5/0", i, bc_a, rv_a);
      end
    end
    repeat (4) beat(0, {4{8'd1}}, {4{8'd1}}, 1'b0, 32'd0);
    idle(1);
    repeat (3) beat(0, {4{8'd1}}, {4{8'd1}}, 1'b0, 32'd0);
    idle(1);
    repeat (3) beat(0, {4{8'd1}}, {4{8'd1}}, 1'b0, 32'd0);
    idle(5);
    n_cmp++;
    if (res_a !== 32'd64 || p_a - p0 != 1 || q_a.size() != 0) begin
      n_err++; $display("FAIL bubble_result: got %0d pulses=%0d want 64 pulses=1", res_a, p_a - p0);
    end
  endtask

  task automatic test_restart;
    int p0;
    p0 = p_a;
    repeat (7) beat(0, {4{8'd5}}, {4{8'd7}}, 1'b0, 32'd0);
    beat(0, {4{8'd1}}, {4{8'd1}}, 1'b1, 32'd0);
    repeat (15) beat(0, {4{8'd1}}, {4{8'd1}}, 1'b0, 32'd0);
    idle(5);
    n_cmp++;
    if (res_a !== 32'd64 || p_a - p0 != 1 || q_a.size() != 0) begin
      n_err++; $display("FAIL restart_result: got %0d pulses=%0d want 64 pulses=1", res_a, p_a - p0);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    repeat (9) beat(0, {4{8'd2}}, {4{8'd2}}, 1'b0, 32'd0);
    reset = 1'b1; en = 1'b1; in_valid = 1'b1; sel = 0;
    @(posedge clk); #1;
    n_cmp++;
    if ({res_a, rv_a, bc_a} !== '0) begin
      n_err++; $display("FAIL reset_mid: got res=%0d vld=%b cnt=%0d want 0", res_a, rv_a, bc_a);
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin m_acc[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0; end
    p0 = p_a;
    idle(5);
    n_cmp++;
    if (p_a != p0 || bc_a !== 5'd0) begin
      n_err++; $display("FAIL reset_drop: got pulses=%0d cnt=%0d want 0/0", p_a - p0, bc_a);
    end
    repeat (16) beat(0, {4{8'd2}}, {4{8'd2}}, 1'b0, 32'd0);
    idle(5);
    n_cmp++;
    if (res_a !== 32'd256 || q_a.size() != 0) begin
      n_err++; $display("FAIL reset_regroup: got %0d want 256", res_a);
    end
  endtask

  task automatic test_acc_overflow;
    logic [19:0] want;
`ifdef MAC_ARRAY_ACC_SAT_EN
    want = 20'h7FFFF;
`else
    want = 20'hFC040;
`endif
    beat(2, {4{8'd127}}, {4{8'd127}}, 1'b1, 32'd0);
    repeat (15) beat(2, {4{8'd127}}, {4{8'd127}}, 1'b0, 32'd0);
    idle(3);
    n_cmp++;
    if (rv_c !== 1'b1 || res_c !== want) begin
      n_err++; $display("FAIL overflow_result: got %h vld=%b want %h vld=1", res_c, rv_c, want);
    end
`ifdef MAC_ARRAY_ACC_SAT_EN
    n_cmp++;
    if (sat_c !== 1'b1) begin
      n_err++; $display("FAIL overflow_sat: got %b want 1", sat_c);
    end
`endif
    idle(2);
    beat(2, {4{8'd1}}, {4{8'd1}}, 1'b1, 32'd0);
    repeat (15) beat(2, {4{8'd1}}, {4{8'd1}}, 1'b0, 32'd0);
    idle(3);
    n_cmp++;
    if (rv_c !== 1'b1 || res_c !== 20'd64) begin
      n_err++; $display("FAIL small_result: got %0d vld=%b want 64 vld=1", res_c, rv_c);
    end
`ifdef MAC_ARRAY_ACC_SAT_EN
    n_cmp++;
    if (sat_c !== 1'b0) begin
      n_err++; $display("FAIL small_sat: got %b want 0", sat_c);
    end
`endif
    idle(2);
    n_cmp++;
    if (q_c.size() != 0) begin
      n_err++; $display("FAIL overflow_drain: got %0d pending want 0", q_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_unsigned_stream();
    test_bubble_stall();
    test_restart();
    test_reset_mid();
    test_acc_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
